// File: rtl/reg_file_read_ctrl.sv
// Read-side controller: issues one-cycle-latency register file reads and buffers returned slots.
// Optional REG_READ_CTRL_FALLTHROUGH_EN presents returned data in the same cycle when the buffer is empty.
module reg_file_read_ctrl #(
    parameter int unsigned data_length  = 512,
    parameter int unsigned register_num = 32,
    parameter int unsigned buf_depth    = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid_i,
    input  logic [$clog2(register_num)-1:0]   req_addr_i,
    output logic                              req_ready_o,
    output logic [$clog2(register_num)-1:0]   addr0_o,
    output logic                              rd0_o,
    input  logic [data_length-1:0]            reg_data_i,
    output logic                              out_valid_o,
    output logic [data_length-1:0]            out_data_o,
    output logic [$clog2(register_num)-1:0]   out_addr_o,
    input  logic                              out_ready_i,
    output logic                              busy_o
);
    localparam int unsigned register_width = $clog2(register_num);
    localparam int unsigned PtrW = $clog2(buf_depth);
    localparam int unsigned CntW = $clog2(buf_depth + 1);
    localparam int unsigned EntW = register_width + data_length;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(buf_depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(buf_depth);
    localparam logic [CntW:0]   DepthC  = (CntW + 1)'(buf_depth);

    logic                      inflight_q;
    logic [register_width-1:0] inflight_addr_q;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [EntW-1:0]           mem_q [buf_depth];

    logic            accept, push, pop, buf_empty, ft_take;
    logic [CntW:0]   credit_used;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // Credit counts the read in flight so a returning slot always has a free entry.
    assign credit_used = {1'b0, cnt_q} + {{CntW{1'b0}}, inflight_q};
    assign req_ready_o = ~rst & (credit_used < DepthC);
    assign accept      = req_valid_i & req_ready_o;
    assign rd0_o       = accept;
    assign addr0_o     = req_addr_i;
    assign buf_empty   = (cnt_q == '0);

`ifdef REG_READ_CTRL_FALLTHROUGH_EN
    assign ft_take     = inflight_q & buf_empty & out_ready_i;
    assign out_valid_o = ~rst & (~buf_empty | inflight_q);
    assign {out_addr_o, out_data_o} = buf_empty ? {inflight_addr_q, reg_data_i}
                                                : mem_q[rd_ptr_q];
`else
    assign ft_take     = 1'b0;
    assign out_valid_o = ~rst & ~buf_empty;
    assign {out_addr_o, out_data_o} = mem_q[rd_ptr_q];
`endif

    assign push   = inflight_q & ~ft_take;
    assign pop    = ~rst & ~buf_empty & out_ready_i;
    assign busy_o = ~rst & (inflight_q | ~buf_empty);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            cnt_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                inflight_addr_q <= req_addr_i;
            end
            cnt_q <= cnt_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Storage is not reset; entries are only visible through cnt_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {inflight_addr_q, reg_data_i};
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt_q == FullCnt));

endmodule

// File: doc/reg_file_read_ctrl.md
# reg_file_read_ctrl

Read-side controller for the slot register file. It accepts slot read requests on a valid/ready port and drives the register file's one-cycle-latency read port (`addr0`/`rd0`). It captures the returned `reg_data` into a small output buffer and presents each slot's data with its address on a backpressured valid/ready output. It sits between the register file and the downstream consumer, so the consumer never has to track read latency or risk losing data under backpressure.

## Interface
- `data_length`, 512, width of one slot.
- `register_num`, 32, number of slots; `register_width` = clogb(`register_num`) (localparam).
- `buf_depth`, 3, output buffer entries; legal range is 2..8.

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid_i`  in  1  a read request is present.
- `req_addr_i`  in  `register_width`  slot to read.
- `req_ready_o`  out  1  the request is accepted when `req_valid_i & req_ready_o`.
- `addr0_o`  out  `register_width`  to register file `addr0_i`.
- `rd0_o`  out  1  to register file `rd0_i`.
- `reg_data_i`  in  `data_length`  from register file `reg_data_o`; valid the cycle after `rd0_o`.
- `out_valid_o`  out  1  output data present.
- `out_data_o`  out  `data_length`  slot data.
- `out_addr_o`  out  `register_width`  slot address that the data belongs to.
- `out_ready_i`  in  1  consumer accepts when `out_valid_o & out_ready_i`.
- `busy_o`  out  1  a read is in flight or the buffer is non-empty.

## Operation
- **Request accept.** `rd0_o = req_valid_i & req_ready_o` and `addr0_o = req_addr_i`. Both are combinational, and the accepted request goes to the register file in the same cycle.
- **In-flight tracking.** The `inflight` flop is set on accept. `inflight_addr` registers `req_addr_i`. `inflight` clears the following cycle unless another accept occurs.
- **Capture.** In the cycle where `inflight` = 1, `{inflight_addr, reg_data_i}` is pushed into the buffer. The exception is when it is passed through directly (see Configuration).
- **Buffer.** Circular FIFO of `buf_depth` entries:
  - Read and write pointers wrap modulo `buf_depth`.
  - Count `cnt` runs 0..`buf_depth`.
  - Push and pop in the same cycle leave `cnt` unchanged.
  - `out_data_o`/`out_addr_o` show the head entry. They are don't-care when `out_valid_o` = 0.
- **Credit.** `req_ready_o = ~rst & ((cnt + inflight) < buf_depth)`.
  - It depends only on registered state. There is no path from `req_valid_i` or `out_ready_i`.
  - Because of this, the buffer can never overflow. An overflow push is an assertion failure.
- **Ordering.** Output order equals accept order. Repeated reads of the same slot are allowed and each returns a separate entry.
- **Busy.** `busy_o = inflight | (cnt != 0)`.
- **Ownership.** Write/valid-bitmap coherency stays with the register file, which clears the slot valid on `rd0`. This block does not check slot validity.
- **Output stability.** Once `out_valid_o` rises, `out_data_o`/`out_addr_o` hold until the handshake completes.

## Timing
- **Reset.** While `rst` = 1 and in the cycle after it:
  - `req_ready_o` = 0 during reset.
  - `rd0_o` = 0 and `addr0_o` = `req_addr_i`.
  - `out_valid_o` = 0.
  - `busy_o` = 0.
  - `cnt`, pointers and `inflight` are 0.
- **Reset mid-operation.** In-flight data and buffered entries are discarded. No output handshake completes in the reset cycle.
- **Latency, request accept (T) to `out_valid_o`:**
  - 2 cycles (T+2) without the macro.
  - 1 cycle (T+1) with the macro when the buffer is empty.
- **Throughput.** One request per cycle is sustained while `out_ready_i` = 1, provided `buf_depth` ≥ 3 (macro off) or ≥ 2 (macro on).
- **Backpressure.**
  - When `out_ready_i` = 0, `req_ready_o` drops once `cnt + inflight` = `buf_depth`.
  - It reasserts the cycle after the first pop.

## Configuration
- **`REG_READ_CTRL_FALLTHROUGH_EN`.** When defined, and `inflight` = 1 with `cnt` = 0:
  - `out_valid_o` = 1 in the same cycle, with `out_data_o = reg_data_i` and `out_addr_o = inflight_addr`.
  - If `out_ready_i` = 1, no push occurs. Otherwise the entry is pushed and becomes the head.
- **Not defined.** Returned data is always pushed into the buffer first, so `out_valid_o` comes only from registered state.

## Test plan
- **Single read.** Reset, then request addr 5 (slot 5 = 0xA5…A5) with `out_ready_i` = 1.
  - Macro off: `out_valid_o` at T+2 with data 0xA5…A5 and `out_addr_o` = 5.
  - Macro on: the same values at T+1.
- **Streaming.** 32 back-to-back requests for addrs 0..31 with `out_ready_i` = 1.
  - `req_ready_o` stays 1 throughout.
  - 32 outputs appear in order on consecutive cycles.
- **Backpressure.** `out_ready_i` = 0 with continuous requests.
  - Exactly `buf_depth` (3) requests are accepted, after which `req_ready_o` = 0.
  - After raising `out_ready_i`, all 3 drain in order and `req_ready_o` = 1 the cycle after the first pop.
- **Wrap-around.** 10 requests with `out_ready_i` toggling 1/0 every cycle.
  - All 10 outputs arrive in accept order.
  - `cnt` never exceeds 3 and no data is corrupted.
- **Reset mid-operation.** Assert `rst` for 1 cycle with 2 entries buffered and 1 in flight.
  - Next cycle: `out_valid_o` = 0, `busy_o` = 0, `req_ready_o` = 1.
  - No stale output ever appears.
- **Duplicate address.** Request addr 7 twice back-to-back.
  - Two output entries appear, both with `out_addr_o` = 7 and each with the data returned for its own read.
